// File: rtl/gate_op_arbiter.sv
// ============================================================================
// gate_op_arbiter : four-requester round-robin front end for a shared bitwise
//                   logic unit (INV/AND/OR/NAND/NOR/XOR/XNOR) with a
//                   registered, back-pressured response.
// Optional: define GATE_OP_ARBITER_ERR_EN to add rsp_err (reserved opcode flag).
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [11:0]        op_flat,
  input  logic [4*WIDTH-1:0] a_flat,
  input  logic [4*WIDTH-1:0] b_flat,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
`ifdef GATE_OP_ARBITER_ERR_EN
  output logic               rsp_err,
`endif
  output logic [WIDTH-1:0]   rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       ptr;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic [WIDTH-1:0] result;

  logic [2:0]       op_arr [4];
  logic [WIDTH-1:0] a_arr  [4];
  logic [WIDTH-1:0] b_arr  [4];

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign op_arr[i] = op_flat[3*i +: 3];
    assign a_arr[i]  = a_flat[WIDTH*i +: WIDTH];
    assign b_arr[i]  = b_flat[WIDTH*i +: WIDTH];
  end

  // Rotating priority: scan upward from ptr, first asserted request wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + k[1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    case (op_q)
      3'd0:    result = ~a_q;
      3'd1:    result = a_q & b_q;
      3'd2:    result = a_q | b_q;
      3'd3:    result = ~(a_q & b_q);
      3'd4:    result = ~(a_q | b_q);
      3'd5:    result = a_q ^ b_q;
      3'd6:    result = ~(a_q ^ b_q);
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 2'd0;
      op_q      <= 3'd0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_data  <= '0;
`ifdef GATE_OP_ARBITER_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_q   <= op_arr[winner];
            a_q    <= a_arr[winner];
            b_q    <= b_arr[winner];
            rsp_id <= winner;
            gnt    <= 4'b0001 << winner;
            ptr    <= winner + 2'd1;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_valid <= 1'b1;
          gnt       <= 4'd0;
`ifdef GATE_OP_ARBITER_ERR_EN
          rsp_err   <= (op_q == 3'd7);
`endif
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: begin
          gnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
// ============================================================================
// tb_gate_op_arbiter : scoreboard bench for gate_op_arbiter (WIDTH=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_op_arbiter;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [11:0]      op_flat;
  logic [4*WIDTH-1:0] a_flat;
  logic [4*WIDTH-1:0] b_flat;
  logic [3:0]       gnt;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef GATE_OP_ARBITER_ERR_EN
  logic             rsp_err;
`endif

  typedef struct packed {
    logic [1:0]       id;
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests_run = 0;
  int   tests_failed = 0;

  gate_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_flat(op_flat),
    .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
`ifdef GATE_OP_ARBITER_ERR_EN
    .rsp_err(rsp_err),
`endif
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Reference: per-opcode truth table indexed by {a_bit, b_bit}.
  function automatic logic [WIDTH-1:0] model_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [3:0] tt;
    logic [WIDTH-1:0] y;
    case (op)
      3'd0: tt = 4'b0011;
      3'd1: tt = 4'b1000;
      3'd2: tt = 4'b1110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b0110;
      3'd6: tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < WIDTH; i++) y[i] = tt[{a[i], b[i]}];
    return y;
  endfunction

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_flat[3*id +: 3]         = op;
    a_flat[WIDTH*id +: WIDTH]  = a;
    b_flat[WIDTH*id +: WIDTH]  = b;
  endtask

  task automatic push_exp(input int id, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t x;
    x.id   = id[1:0];
    x.data = model_f(op, a, b);
    x.err  = (op == 3'd7);
    sb.push_back(x);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (gnt !== 4'd0) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    tests_run++; if ({busy, rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_busy_valid: got %b want 00", {busy, rsp_valid}); end
    tests_run++; if ({rsp_id, rsp_data} !== '0) begin tests_failed++; $display("FAIL reset_id_data: got %h/%h want 0/00", rsp_id, rsp_data); end
    // Start a transaction, stall it in RESP, then reset asynchronously.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, 3'd2, 8'h12, 8'h34);
    req = 4'b0001;
    @(posedge clk); #1; req = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_valid: got %b want 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({gnt, busy, rsp_valid} !== 6'd0) begin tests_failed++; $display("FAIL async_reset_ctl: got %b want 000000", {gnt, busy, rsp_valid}); end
    tests_run++; if ({rsp_id, rsp_data} !== '0) begin tests_failed++; $display("FAIL async_reset_data: got %h/%h want 0/00", rsp_id, rsp_data); end
    @(posedge clk); #1; rst_n = 1'b1; rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++; if ({busy, rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL idle_after_reset: got %b want 00", {busy, rsp_valid}); end
    end
  endtask

  task automatic test_opcodes();
    logic [WIDTH-1:0] table_y [7];
    table_y = '{8'h0F, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    for (int op = 0; op < 7; op++) begin
      @(posedge clk); #1;
      set_req(2, op[2:0], 8'hF0, 8'hCC);
      req = 4'b0100;
      e.id = 2'd2; e.data = table_y[op]; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL op%0d_gnt_early: got %b want 0000", op, gnt); end
      @(posedge clk); #1; req = 4'b0000;
      @(negedge clk);
      tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL op%0d_gnt: got %b want 0100", op, gnt); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL op%0d_busy: got %b want 1", op, busy); end
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL op%0d_valid: got %b want 1", op, rsp_valid); end
      tests_run++; if (rsp_data !== e.data) begin tests_failed++; $display("FAIL op%0d_data: got %h want %h", op, rsp_data, e.data); end
      tests_run++; if (rsp_id !== e.id) begin tests_failed++; $display("FAIL op%0d_id: got %0d want %0d", op, rsp_id, e.id); end
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL op%0d_gnt_off: got %b want 0000", op, gnt); end
    end
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int last_t = 0;
    logic [3:0] exp_g;
    // Serve requester 3 so the pointer wraps to 0.
    @(posedge clk); #1;
    set_req(3, 3'd5, 8'h99, 8'h0F); push_exp(3, 3'd5, 8'h99, 8'h0F);
    req = 4'b1000;
    @(posedge clk); #1; req = 4'b0000;
    @(negedge clk);
    tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL rr_prime_gnt: got %b want 1000", gnt); end
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL rr_prime_rsp: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 8'(8'h3C + 17 * i), 8'(8'h5A ^ (3 * i)));
    req = 4'b1111;
    for (int t = 0; t < 40 && !(grants == 5 && sb.size() == 0); t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("FAIL rr_unexpected_rsp: got id %0d want none", rsp_id); end
        else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data} !== {e.id, e.data}) begin tests_failed++; $display("FAIL rr_rsp: got %0d/%h want %0d/%h", rsp_id, rsp_data, e.id, e.data); end
        end
      end
      if (gnt !== 4'b0000) begin
        exp_g = 4'b0001 << (grants % 4);
        tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL rr_gnt%0d: got %b want %b", grants, gnt, exp_g); end
        if (grants > 0) begin
          tests_run++; if (t - last_t != 3) begin tests_failed++; $display("FAIL rr_spacing%0d: got %0d want 3", grants, t - last_t); end
        end
        push_exp(grants % 4, 3'((grants % 4) + 1), 8'(8'h3C + 17 * (grants % 4)), 8'(8'h5A ^ (3 * (grants % 4))));
        last_t = t;
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 5) req = 4'b0000;
    end
    tests_run++; if (grants != 5 || sb.size() != 0) begin tests_failed++; $display("FAIL rr_count: got %0d grants/%0d pending want 5/0", grants, sb.size()); end
    sb.delete();
  endtask

  task automatic test_pointer_skip();
    @(posedge clk); #1;
    set_req(1, 3'd1, 8'hAA, 8'h0F); push_exp(1, 3'd1, 8'hAA, 8'h0F);
    req = 4'b0010;
    @(posedge clk); #1; req = 4'b0000;
    @(negedge clk);
    tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL skip_first_gnt: got %b want 0010", gnt); end
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL skip_first_rsp: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
    @(posedge clk); #1;
    set_req(0, 3'd4, 8'h81, 8'h18); set_req(1, 3'd6, 8'h55, 8'h0F);
    push_exp(0, 3'd4, 8'h81, 8'h18);
    req = 4'b0011;
    @(posedge clk); #1; req = 4'b0010;
    @(negedge clk);
    tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL skip_gnt: got %b want 0001", gnt); end
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL skip_rsp0: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
    push_exp(1, 3'd6, 8'h55, 8'h0F);
    @(posedge clk); @(posedge clk); #1; req = 4'b0000;
    @(negedge clk);
    tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL skip_gnt1: got %b want 0010", gnt); end
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL skip_rsp1: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
  endtask

  task automatic test_back_pressure();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(2, 3'd3, 8'h6E, 8'hB5); push_exp(2, 3'd3, 8'h6E, 8'hB5);
    req = 4'b0100;
    @(posedge clk); #1;
    set_req(3, 3'd0, 8'h5A, 8'hFF);
    req = 4'b1000;
    @(negedge clk);
    tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL bp_gnt2: got %b want 0100", gnt); end
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = sb[0];
      tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL bp_hold%0d: got %b/%0d/%h want 1/%0d/%h", i, rsp_valid, rsp_id, rsp_data, e.id, e.data); end
      tests_run++; if ({gnt, busy} !== 5'b00001) begin tests_failed++; $display("FAIL bp_nognt%0d: got %b/%b want 0000/1", i, gnt, busy); end
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL bp_release: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
    @(posedge clk); @(negedge clk);
    tests_run++; if ({rsp_valid, gnt} !== 5'd0) begin tests_failed++; $display("FAIL bp_drop: got %b/%b want 0/0000", rsp_valid, gnt); end
    push_exp(3, 3'd0, 8'h5A, 8'hFF);
    @(posedge clk); #1; req = 4'b0000;
    @(negedge clk);
    tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL bp_gnt3: got %b want 1000", gnt); end
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL bp_rsp3: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
  endtask

  task automatic test_capture_reserved();
    @(posedge clk); #1;
    set_req(0, 3'd5, 8'hA5, 8'h0F); push_exp(0, 3'd5, 8'hA5, 8'h0F);
    req = 4'b0001;
    @(posedge clk); #1;
    set_req(0, 3'd2, 8'h00, 8'hF0);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL capture_rsp: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
`ifdef GATE_OP_ARBITER_ERR_EN
    tests_run++; if (rsp_err !== e.err) begin tests_failed++; $display("FAIL capture_err: got %b want %b", rsp_err, e.err); end
`endif
    @(posedge clk); #1;
    set_req(1, 3'd7, 8'hFF, 8'hFF); push_exp(1, 3'd7, 8'hFF, 8'hFF);
    req = 4'b0010;
    @(posedge clk); #1; req = 4'b0000;
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    tests_run++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin tests_failed++; $display("FAIL reserved_rsp: got %b/%0d/%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
`ifdef GATE_OP_ARBITER_ERR_EN
    tests_run++; if (rsp_err !== e.err) begin tests_failed++; $display("FAIL reserved_err: got %b want %b", rsp_err, e.err); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 4'd0; op_flat = '0; a_flat = '0; b_flat = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_opcodes();
    test_round_robin();
    test_pointer_skip();
    test_back_pressure();
    test_capture_reserved();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shared bitwise logic unit. Four requesters time-share it under round-robin arbitration.
- Function set: INV, AND2, OR2, NAND2, NOR2, XOR2, XNOR2, applied bitwise across a WIDTH-bit operand pair.
- Sequenced by a 3-state FSM with a registered result and valid/ready back-pressure on the response side.
- Sits between the lab's gate library datapath and any block needing logic ops without owning its own gates.

Parameters:
- WIDTH, 8, operand and result width in bits (legal 1..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request; bit i = requester i.
- op_flat  input  12  3-bit opcode per requester; requester i uses bits [3i+2:3i].
- a_flat  input  4*WIDTH  operand A per requester; requester i uses bits [WIDTH*(i+1)-1:WIDTH*i].
- b_flat  input  4*WIDTH  operand B per requester; same slicing as a_flat.
- gnt  output  4  one-hot grant pulse.
- busy  output  1  high whenever FSM is not IDLE.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  2  index of the requester that owns rsp_data.
- rsp_data  output  WIDTH  registered result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0; rr pointer=0.
- Reset mid-operation: in-flight transaction is dropped; no response is produced.
- Opcodes (Y is bitwise):
  - 0 = ~A (B ignored)
  - 1 = A&B
  - 2 = A|B
  - 3 = ~(A&B)
  - 4 = ~(A|B)
  - 5 = A^B
  - 6 = ~(A^B)
  - 7 = reserved, Y = 0.
- IDLE:
  - Search req starting at ptr, ascending, mod 4; first set bit wins.
  - If a winner exists, at the clock edge: latch winner's op/A/B; rsp_id<=winner; gnt<=onehot(winner); ptr<=(winner+1) mod 4; state<=EXEC.
  - If req==0, stay in IDLE; ptr unchanged.
- EXEC (exactly 1 cycle):
  - gnt is high only in this cycle.
  - At the edge: rsp_data<=f(op,A,B) from the latched operands; rsp_valid<=1; gnt<=0; state<=RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid & rsp_ready at an edge.
  - On that edge: rsp_valid<=0, state<=IDLE. rsp_data and rsp_id keep their last values.
- No arbitration occurs in EXEC or RESP. Pending requests wait.
- busy = (state != IDLE), registered with the state.
- Requester rules:
  - Hold req, op and operands stable until it sees its gnt bit.
  - Operands are captured on the edge that leaves IDLE, so later changes do not affect the result.
  - req still high in the cycle after gnt counts as a new request.
- Withdrawn request: req dropped before being granted is legal; no grant is issued.
- Latency: req seen in IDLE at cycle 0 → gnt in cycle 1 → rsp_valid in cycle 2.
- Throughput: with rsp_ready held high, 1 transaction per 3 cycles.
- Fairness: all four requesting continuously yields grant order 0,1,2,3,0,...; no requester starves.

Optional Feature:
- Macro: GATE_OP_ARBITER_ERR_EN.
- Defined: adds output port rsp_err (1 bit).
  - Reset value 0.
  - Loaded alongside rsp_data: 1 when the latched op==7, else 0.
  - Valid only while rsp_valid=1.
- Undefined: port absent; op 7 silently returns 0.

Test Plan:
- Reset: assert rst_n=0 mid-RESP → gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0 immediately (async); after release, idle with req=0 → busy stays 0.
- Opcode sweep: WIDTH=8, requester 2, A=0xF0, B=0xCC, ops 0..6, rsp_ready=1 → rsp_data = 0x0F, 0xC0, 0xFC, 0x3F, 0x03, 0x3C, 0xC3; rsp_id=2; gnt=4'b0100 one cycle each; rsp_valid 2 cycles after req.
- Round-robin: req=4'b1111 held, rsp_ready=1 → gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- Pointer skip: after requester 1 is served, req=4'b0011 → next grant is 0, not 1.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid, with req=4'b1000 pending → rsp_data/rsp_id stable, no gnt; rsp_ready=1 → rsp_valid drops, gnt=1000 issued the next cycle.
- Operand capture and reserved op: change A one cycle after the IDLE→EXEC edge → result uses the original A; op=7 → rsp_data=0x00, and rsp_err=1 when GATE_OP_ARBITER_ERR_EN is defined.
